// File: rtl/arbitro_paso8b_pkg.sv
// Shared constants and types for the byte arbiter and the paso8bto32b converter it feeds.
package arbitro_paso8b_pkg;

   localparam int NUM_REQ        = 4;
   localparam int BYTES_PER_WORD = 4;
   localparam int CONV_BYTE_W    = 8;
   localparam int CONV_WORD_W    = CONV_BYTE_W * BYTES_PER_WORD;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      XFER = 2'd1,
      PAD  = 2'd2
   } arb_state_e;

   // Round-robin search always begins one lane past the previous owner.
   function automatic logic [1:0] next_lane(input logic [1:0] lane);
      return lane + 2'd1;
   endfunction

endpackage

// File: rtl/arbitro_paso8b_rr_sel4.sv
// Four-way round-robin selector: first requesting lane at or after ptr, wrapping mod 4.
module rr_sel4 (
   input  logic [3:0] req,
   input  logic [1:0] ptr,
   output logic [1:0] grant,
   output logic       any
);

   logic [1:0] idx_s;

   // Scan from the farthest offset down so the nearest requester wins last.
   always_comb begin
      grant = ptr;
      any   = 1'b0;
      idx_s = ptr;
      for (int i = 3; i >= 0; i--) begin
         idx_s = ptr + 2'(i);
         grant = req[idx_s] ? idx_s : grant;
         any   = any | req[idx_s];
      end
   end

endmodule

// File: rtl/arbitro_paso8b.sv
// Word-atomic round-robin byte arbiter: grants one lane for a 4-byte word, pads aborted words.
module arbitro_paso8b
   import arbitro_paso8b_pkg::*;
#(
   parameter int          TIMEOUT  = 8,
   parameter logic [7:0]  PAD_BYTE = 8'h00
) (
   input  logic               clk_4f,
   input  logic               reset,
   input  logic [NUM_REQ-1:0] req,
   input  logic [7:0]         data_in0,
   input  logic [7:0]         data_in1,
   input  logic [7:0]         data_in2,
   input  logic [7:0]         data_in3,
   output logic [NUM_REQ-1:0] pop,
   output logic [7:0]         data_out,
   output logic               valid_out,
   output logic [1:0]         lane_id,
   output logic               word_start,
   output logic               word_end,
   output logic               word_abort
);

   localparam int                 STALL_W    = $clog2(TIMEOUT + 1);
   localparam logic [STALL_W-1:0] STALL_LAST = STALL_W'(TIMEOUT - 1);
   localparam logic [1:0]         LAST_BYTE  = 2'(BYTES_PER_WORD - 1);

   arb_state_e         state_r;
   logic [1:0]         owner_r;
   logic [1:0]         last_owner_r;
   logic [1:0]         byte_cnt_r;
   logic [STALL_W-1:0] stall_r;

   logic [1:0]         ptr_s;
   logic [1:0]         grant_s;
   logic               any_s;
   logic               owner_req_s;
   logic [7:0]         lane_byte_s;
   logic [NUM_REQ-1:0] pop_s;

   assign ptr_s       = next_lane(last_owner_r);
   assign owner_req_s = req[owner_r];
   assign pop         = pop_s;

   rr_sel4 u_rr_sel4 (
      .req   (req),
      .ptr   (ptr_s),
      .grant (grant_s),
      .any   (any_s)
   );

   // Byte lane of the current owner.
   always_comb begin
      case (owner_r)
         2'd0:    lane_byte_s = data_in0;
         2'd1:    lane_byte_s = data_in1;
         2'd2:    lane_byte_s = data_in2;
         2'd3:    lane_byte_s = data_in3;
         default: lane_byte_s = 8'h00;
      endcase
   end

   // Pop follows the owner's request only while a word is in transfer.
   always_comb begin
      pop_s = {NUM_REQ{1'b0}};
      if ((state_r == XFER) && owner_req_s) begin
         pop_s[owner_r] = 1'b1;
      end else begin
         pop_s = {NUM_REQ{1'b0}};
      end
   end

   // Arbitration FSM and registered byte/marker outputs.
   always_ff @(posedge clk_4f or negedge reset) begin
      if (!reset) begin
         state_r      <= IDLE;
         owner_r      <= 2'd0;
         last_owner_r <= 2'd3;
         byte_cnt_r   <= 2'd0;
         stall_r      <= {STALL_W{1'b0}};
         data_out     <= 8'h00;
         valid_out    <= 1'b0;
         lane_id      <= 2'd0;
         word_start   <= 1'b0;
         word_end     <= 1'b0;
         word_abort   <= 1'b0;
      end else begin
         case (state_r)
            IDLE: begin
               data_out   <= 8'h00;
               valid_out  <= 1'b0;
               word_start <= 1'b0;
               word_end   <= 1'b0;
               word_abort <= 1'b0;
               if (any_s) begin
                  owner_r    <= grant_s;
                  lane_id    <= grant_s;
                  byte_cnt_r <= 2'd0;
                  stall_r    <= {STALL_W{1'b0}};
                  state_r    <= XFER;
               end else begin
                  state_r    <= IDLE;
               end
            end
            XFER: begin
               word_abort <= 1'b0;
               if (owner_req_s) begin
                  data_out   <= lane_byte_s;
                  valid_out  <= 1'b1;
                  word_start <= (byte_cnt_r == 2'd0);
                  word_end   <= (byte_cnt_r == LAST_BYTE);
                  stall_r    <= {STALL_W{1'b0}};
                  byte_cnt_r <= byte_cnt_r + 2'd1;
                  if (byte_cnt_r == LAST_BYTE) begin
                     state_r      <= IDLE;
                     last_owner_r <= owner_r;
                  end else begin
                     state_r      <= XFER;
                  end
               end else begin
                  data_out   <= 8'h00;
                  valid_out  <= 1'b0;
                  word_start <= 1'b0;
                  word_end   <= 1'b0;
                  if (stall_r == STALL_LAST) begin
                     stall_r <= {STALL_W{1'b0}};
                     state_r <= PAD;
                  end else begin
                     stall_r <= stall_r + STALL_W'(1);
                     state_r <= XFER;
                  end
               end
            end
            PAD: begin
               data_out   <= PAD_BYTE;
               valid_out  <= 1'b1;
               word_abort <= 1'b1;
               word_start <= (byte_cnt_r == 2'd0);
               word_end   <= (byte_cnt_r == LAST_BYTE);
               byte_cnt_r <= byte_cnt_r + 2'd1;
               if (byte_cnt_r == LAST_BYTE) begin
                  state_r      <= IDLE;
                  last_owner_r <= owner_r;
               end else begin
                  state_r      <= PAD;
               end
            end
            default: begin
               state_r    <= IDLE;
               byte_cnt_r <= 2'd0;
               stall_r    <= {STALL_W{1'b0}};
               data_out   <= 8'h00;
               valid_out  <= 1'b0;
               word_start <= 1'b0;
               word_end   <= 1'b0;
               word_abort <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_arbitro_paso8b.sv
// Directed bench for arbitro_paso8b with hand-computed expectations and a tiny converter model.
module tb_arbitro_paso8b;
   import arbitro_paso8b_pkg::*;

   logic       clk_4f = 1'b0;
   logic       reset  = 1'b0;
   logic [3:0] req    = 4'b0000;
   logic [7:0] data_in0 = 8'h00, data_in1 = 8'h00, data_in2 = 8'h00, data_in3 = 8'h00;
   logic [3:0] pop;
   logic [7:0] data_out;
   logic       valid_out;
   logic [1:0] lane_id;
   logic       word_start, word_end, word_abort;

   int n_checks = 0;
   int n_err    = 0;

   logic [7:0]             t2 [4] = '{8'hA1, 8'hA2, 8'hA3, 8'hA4};
   logic [7:0]             t7 [4] = '{8'h11, 8'h22, 8'h33, 8'h44};
   logic [CONV_WORD_W-1:0] conv_word;
   logic                   conv_valid;
   logic [1:0]             ln;
   logic [7:0]             exp_b;

   arbitro_paso8b #(.TIMEOUT(8), .PAD_BYTE(8'h00)) dut (
      .clk_4f     (clk_4f),
      .reset      (reset),
      .req        (req),
      .data_in0   (data_in0),
      .data_in1   (data_in1),
      .data_in2   (data_in2),
      .data_in3   (data_in3),
      .pop        (pop),
      .data_out   (data_out),
      .valid_out  (valid_out),
      .lane_id    (lane_id),
      .word_start (word_start),
      .word_end   (word_end),
      .word_abort (word_abort)
   );

   always #5 clk_4f = ~clk_4f;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic clk1();
      @(posedge clk_4f);
      #1;
   endtask

   task automatic chk_byte(input string tag, input logic [7:0] d, input logic [1:0] l,
                           input logic s, input logic e, input logic a);
      chk({tag, ".valid"}, {31'd0, valid_out}, 32'd1);
      chk({tag, ".data"}, {24'd0, data_out}, {24'd0, d});
      chk({tag, ".lane"}, {30'd0, lane_id}, {30'd0, l});
      chk({tag, ".marks"}, {29'd0, word_start, word_end, word_abort}, {29'd0, s, e, a});
   endtask

   task automatic chk_quiet(input string tag);
      chk({tag, ".valid"}, {31'd0, valid_out}, 32'd0);
      chk({tag, ".marks"}, {29'd0, word_start, word_end, word_abort}, 32'd0);
   endtask

   task automatic chk_reset(input string tag);
      chk({tag, ".pop"}, {28'd0, pop}, 32'd0);
      chk({tag, ".data"}, {24'd0, data_out}, 32'd0);
      chk({tag, ".lane"}, {30'd0, lane_id}, 32'd0);
      chk_quiet(tag);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog expired");
   end

   initial begin
      // Reset state, with every lane requesting: nothing may pop.
      #12;
      req = 4'b1111;
      #1;
      chk_reset("reset");
      req = 4'b0000;
      @(negedge clk_4f);
      reset = 1'b1;

      // Single lane 1 streams A1..A4.
      req = 4'b0010;
      data_in1 = t2[0];
      clk1();
      chk("single.grant_valid", {31'd0, valid_out}, 32'd0);
      for (int k = 0; k < 4; k++) begin
         data_in1 = t2[k];
         #1;
         chk("single.pop", {28'd0, pop}, 32'h2);
         clk1();
         chk_byte("single.byte", t2[k], 2'd1, (k == 0), (k == 3), 1'b0);
      end
      req = 4'b0000;
      #1;
      chk("single.pop_after", {28'd0, pop}, 32'd0);
      clk1();
      chk_quiet("single.idle");

      // Lane 2 is granted next, then reset hits during its third byte.
      req = 4'b0100;
      data_in2 = 8'h5A;
      clk1();
      chk("rst.lane_at_grant", {30'd0, lane_id}, 32'd2);
      clk1();
      chk_byte("rst.b0", 8'h5A, 2'd2, 1'b1, 1'b0, 1'b0);
      clk1();
      chk_byte("rst.b1", 8'h5A, 2'd2, 1'b0, 1'b0, 1'b0);
      reset = 1'b0;
      #1;
      chk_reset("rst.mid");
      req = 4'b1111;
      data_in0 = 8'h10;
      data_in1 = 8'h11;
      data_in2 = 8'h12;
      data_in3 = 8'h13;
      #1;
      chk("rst.pop_held", {28'd0, pop}, 32'd0);
      @(negedge clk_4f);
      reset = 1'b1;

      // All four request: grants 0,1,2,3,0 with exactly one bubble per word.
      for (int w = 0; w < 5; w++) begin
         ln = 2'(w % 4);
         exp_b = 8'h10 + {6'd0, ln};
         clk1();
         chk("rr.bubble", {31'd0, valid_out}, 32'd0);
         chk("rr.pop", {28'd0, pop}, {28'd0, 4'(4'b0001 << ln)});
         for (int k = 0; k < 4; k++) begin
            clk1();
            chk_byte("rr.byte", exp_b, ln, (k == 0), (k == 3), 1'b0);
         end
      end
      req = 4'b0000;

      // Lane 3 stalls for three cycles mid-word and then completes.
      req = 4'b1000;
      data_in3 = 8'hD0;
      clk1();
      chk("stall.grant_valid", {31'd0, valid_out}, 32'd0);
      clk1();
      chk_byte("stall.b0", 8'hD0, 2'd3, 1'b1, 1'b0, 1'b0);
      data_in3 = 8'hD1;
      clk1();
      chk_byte("stall.b1", 8'hD1, 2'd3, 1'b0, 1'b0, 1'b0);
      req = 4'b0000;
      for (int s = 0; s < 3; s++) begin
         #1;
         chk("stall.pop", {28'd0, pop}, 32'd0);
         clk1();
         chk_quiet("stall.gap");
      end
      req = 4'b1000;
      data_in3 = 8'hD2;
      clk1();
      chk_byte("stall.b2", 8'hD2, 2'd3, 1'b0, 1'b0, 1'b0);
      data_in3 = 8'hD3;
      clk1();
      chk_byte("stall.b3", 8'hD3, 2'd3, 1'b0, 1'b1, 1'b0);
      req = 4'b0000;
      clk1();
      chk_quiet("stall.idle");

      // Lane 0 drops after two bytes for eight cycles: padded, lane 1 stays locked out.
      req = 4'b0011;
      data_in0 = 8'hE0;
      data_in1 = 8'hB1;
      clk1();
      chk("abort.lane_at_grant", {30'd0, lane_id}, 32'd0);
      clk1();
      chk_byte("abort.b0", 8'hE0, 2'd0, 1'b1, 1'b0, 1'b0);
      data_in0 = 8'hE1;
      clk1();
      chk_byte("abort.b1", 8'hE1, 2'd0, 1'b0, 1'b0, 1'b0);
      req = 4'b0010;
      for (int s = 0; s < 8; s++) begin
         #1;
         chk("abort.pop_locked", {28'd0, pop}, 32'd0);
         clk1();
         chk_quiet("abort.stall");
      end
      #1;
      chk("abort.pad_pop", {28'd0, pop}, 32'd0);
      clk1();
      chk_byte("abort.pad2", 8'h00, 2'd0, 1'b0, 1'b0, 1'b1);
      clk1();
      chk_byte("abort.pad3", 8'h00, 2'd0, 1'b0, 1'b1, 1'b1);
      clk1();
      chk("abort.next_valid", {31'd0, valid_out}, 32'd0);
      chk("abort.next_lane", {30'd0, lane_id}, 32'd1);
      for (int k = 0; k < 4; k++) begin
         clk1();
         chk_byte("abort.next_byte", 8'hB1, 2'd1, (k == 0), (k == 3), 1'b0);
      end
      req = 4'b0000;

      // Lane 2 word assembled by a paso8bto32b model, then regranted after one bubble.
      req = 4'b0100;
      conv_word = '0;
      conv_valid = 1'b0;
      clk1();
      for (int k = 0; k < 4; k++) begin
         data_in2 = t7[k];
         clk1();
         if (valid_out && word_start) begin
            conv_word = {{(CONV_WORD_W - CONV_BYTE_W){1'b0}}, data_out};
         end else if (valid_out) begin
            conv_word = {conv_word[CONV_WORD_W-CONV_BYTE_W-1:0], data_out};
         end else begin
            conv_word = conv_word;
         end
         conv_valid = valid_out && word_end && !word_abort;
      end
      chk("conv.word", conv_word, 32'h11223344);
      chk("conv.valid", {31'd0, conv_valid}, 32'd1);
      clk1();
      chk("repeat.bubble", {31'd0, valid_out}, 32'd0);
      clk1();
      chk_byte("repeat.b0", 8'h44, 2'd2, 1'b1, 1'b0, 1'b0);
      req = 4'b0000;

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
      $finish;
   end

endmodule

// File: doc/arbitro_paso8b.md
ARBITRO_PASO8B -- requirements
Module: arbitro_paso8b

Interface
REQ-001 SHALL have parameter TIMEOUT, default 8: max consecutive stall cycles tolerated inside a word before padding.
REQ-002 SHALL have parameter PAD_BYTE, default 8'h00: filler byte used when a word is aborted.
REQ-003 SHALL have port clk_4f  input  1: single byte-rate clock; all state on rising edge.
REQ-004 SHALL have port reset  input  1: asynchronous, active-low reset (0 = reset asserted).
REQ-005 SHALL have port req  input  4: req[i]=1 means requester i holds a byte.
REQ-006 SHALL have ports data_in0..data_in3  input  8 each: requester byte lanes.
REQ-007 SHALL have port pop  output  4: one-hot; pop[i]=1 means requester i's byte is consumed this cycle.
REQ-008 SHALL have port data_out  output  8: byte to converter data_in.
REQ-009 SHALL have port valid_out  output  1: drives converter valid_0.
REQ-010 SHALL have port lane_id  output  2: owner of the word currently in transfer.
REQ-011 SHALL have ports word_start, word_end, word_abort  output  1 each: per-word markers aligned with data_out.

Function
REQ-012 SHALL implement FSM states IDLE, XFER, PAD.
REQ-013 IDLE: if req!=0, SHALL pick lane round-robin, starting at (last_owner+1) mod 4, register it as owner, set byte_cnt=0, go XFER; else stay.
REQ-014 XFER: pop[owner] SHALL equal req[owner] (combinational); all other pop bits 0.
REQ-015 Each pop SHALL cause data_out=data_inN and valid_out=1 on the next cycle (registered, latency 1); otherwise valid_out=0 next cycle.
REQ-016 byte_cnt (2 bits) SHALL increment per pop; word_start=1 with byte 0, word_end=1 with byte 3.
REQ-017 After the 4th pop SHALL return to IDLE and update last_owner; one bubble cycle between words is required.
REQ-018 Grant SHALL be word-atomic: other lanes' req ignored until owner completes or aborts.
REQ-019 Stall counter SHALL increment each XFER cycle with req[owner]=0, clear on pop; reaching TIMEOUT SHALL go PAD.
REQ-020 PAD: SHALL emit remaining (4-byte_cnt) bytes as PAD_BYTE with valid_out=1, word_abort=1, word_end on last, pop=0; then IDLE.
REQ-021 Owner dropping req then reasserting before TIMEOUT SHALL resume without padding.
REQ-022 Only one lane requesting SHALL be granted repeatedly (no dead cycles beyond REQ-017).
REQ-023 Simultaneous req from all four SHALL yield grant order 0,1,2,3,0 after reset.

Reset
REQ-024 reset=0 SHALL immediately force IDLE, byte_cnt=0, stall=0, last_owner=3, pop=0, data_out=0, valid_out=0, lane_id=0, word_start=word_end=word_abort=0.
REQ-025 Reset mid-word SHALL discard the partial word without padding; release synchronous to clk_4f.

Structure
REQ-026 State encoding, NUM_REQ=4, and byte-per-word=4 constants SHALL live in a shared include with the paso8bto32b constants.
REQ-027 Round-robin selector SHALL be one sub-module rr_sel4 (4-bit req, 2-bit pointer in; 2-bit grant, any out).
REQ-028 Both behavioural and synthesized versions SHALL be checked against each other by a probador-style bench.

Verification
REQ-029 Single lane: req=4'b0010 continuous, data_in1=A1,A2,A3,A4 -> four valid bytes, lane_id=1, word_start on A1, word_end on A4.
REQ-030 All lanes req continuous -> lane_id sequence 0,1,2,3,0, one bubble between words.
REQ-031 Owner stalls 3 cycles mid-word (TIMEOUT=8) -> valid_out gaps, no word_abort, word completes.
REQ-032 Owner drops req after 2 bytes for 8 cycles -> two bytes 8'h00 with word_abort=1, word_end on last, next lane granted.
REQ-033 reset=0 during byte 2 -> all outputs 0 within same cycle, after release first grant goes to lane 0.
REQ-034 Chain into paso8bto32b: bytes 11,22,33,44 -> converter data_out=32'h11223344, valid_out=1.
